// File: rtl/dll_pkg.sv
// Shared DLL definitions: DLCMSM encoding, FC credit types and field widths,
// and the UpdateFC scheduler state encoding.
package dll_pkg;
    localparam logic [1:0] DLC_DL_ACTIVE = 2'b11;
    localparam int         HDR_CRED_W    = 8;
    localparam int         DATA_CRED_W   = 12;

    typedef enum logic [1:0] {
        FC_P   = 2'b00,
        FC_NP  = 2'b01,
        FC_CPL = 2'b10
    } fc_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        HOLD  = 2'b10
    } sched_state_e;

    // Next type in P -> NP -> Cpl -> P order.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction
endpackage

// File: rtl/dll_fc_rr_arbiter.sv
// Three-way round-robin pick: first requesting type at or after ptr.
// Grants only while the scheduler is ready to take a new request (advance).
module dll_fc_rr_arbiter
    import dll_pkg::*;
(
    input  logic [2:0] req,
    input  logic       advance,
    input  logic [1:0] ptr,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);
    logic [1:0] w_i0;
    logic [1:0] w_i1;
    logic [1:0] w_i2;

    assign w_i0 = (ptr == 2'd3) ? 2'd0 : ptr;
    assign w_i1 = rr_next(w_i0);
    assign w_i2 = rr_next(w_i1);

    always_comb begin
        grant_valid = advance && (req != 3'b000);
        grant_idx   = w_i0;
        if (req[w_i0])      grant_idx = w_i0;
        else if (req[w_i1]) grant_idx = w_i1;
        else if (req[w_i2]) grant_idx = w_i2;
    end
endmodule

// File: rtl/dll_tx_fc_update_scheduler.sv
// Schedules UpdateFC DLLP requests for P/NP/Cpl credits from allocation changes,
// link-up and a periodic refresh, one type at a time with a fixed idle gap.
module dll_tx_fc_update_scheduler
    import dll_pkg::*;
#(
    parameter int UPDATE_PERIOD = 1024,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             dlc_state_i,
    input  logic [HDR_CRED_W-1:0]  ph_alloc_i,
    input  logic [DATA_CRED_W-1:0] pd_alloc_i,
    input  logic [HDR_CRED_W-1:0]  nph_alloc_i,
    input  logic [DATA_CRED_W-1:0] npd_alloc_i,
    input  logic [HDR_CRED_W-1:0]  cplh_alloc_i,
    input  logic [DATA_CRED_W-1:0] cpld_alloc_i,
    output logic [HDR_CRED_W-1:0]  hdr_credit_o,
    output logic [DATA_CRED_W-1:0] data_credit_o,
    output logic [1:0]             update_type_o,
    output logic                   update_req_o
);
    localparam int TW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic                              w_active;
    logic                              w_entry;
    logic                              w_expire;
    logic                              w_issue;
    logic                              w_hold_last;
    logic                              w_advance;
    logic                              w_load;
    logic                              w_grant_valid;
    logic [1:0]                        w_grant_idx;
    logic [2:0]                        w_pend_nxt;
    logic [2:0][HDR_CRED_W-1:0]        w_hdr_in;
    logic [2:0][DATA_CRED_W-1:0]       w_data_in;
    sched_state_e                      w_state_nxt;

    logic                              r_active_q;
    logic [2:0]                        r_pending;
    logic [2:0][HDR_CRED_W-1:0]        r_last_hdr;
    logic [2:0][DATA_CRED_W-1:0]       r_last_data;
    logic [TW-1:0]                     r_timer;
    logic [HW-1:0]                     r_hold_cnt;
    logic [1:0]                        r_ptr;
    sched_state_e                      r_state;
    fc_type_e                          r_type;
    logic [HDR_CRED_W-1:0]             r_hdr;
    logic [DATA_CRED_W-1:0]            r_data;

    assign w_active    = (dlc_state_i == DLC_DL_ACTIVE);
    assign w_entry     = w_active && !r_active_q;
    assign w_expire    = w_active && (r_timer == TW'(UPDATE_PERIOD - 1));
    assign w_issue     = (r_state == ISSUE);
    assign w_hold_last = (r_state == HOLD) && (r_hold_cnt == '0);
    // The last HOLD cycle doubles as the IDLE pick so strobes are 1+HOLD_CYCLES apart.
    assign w_advance   = w_active && ((r_state == IDLE) || w_hold_last);

    assign w_hdr_in  = {cplh_alloc_i, nph_alloc_i, ph_alloc_i};
    assign w_data_in = {cpld_alloc_i, npd_alloc_i, pd_alloc_i};

    dll_fc_rr_arbiter u_arb (
        .req         (r_pending),
        .advance     (w_advance),
        .ptr         (r_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    for (genvar g = 0; g < 3; g++) begin : g_type
        logic                   w_mine;
        logic [HDR_CRED_W-1:0]  w_cmp_hdr;
        logic [DATA_CRED_W-1:0] w_cmp_data;
        logic                   w_set;

        // During its own ISSUE a type compares against the snapshot being sent.
        assign w_mine     = w_issue && (r_type == fc_type_e'(g));
        assign w_cmp_hdr  = w_mine ? r_hdr  : r_last_hdr[g];
        assign w_cmp_data = w_mine ? r_data : r_last_data[g];
        assign w_set      = w_active && ((w_hdr_in[g] != w_cmp_hdr) ||
                            (w_data_in[g] != w_cmp_data) || w_expire || w_entry);
        assign w_pend_nxt[g] = (r_pending[g] && !w_mine) || w_set;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = ISSUE;
                    w_load      = 1'b1;
                end
            end
            ISSUE: w_state_nxt = HOLD;
            HOLD: begin
                if (w_hold_last) begin
                    w_state_nxt = w_grant_valid ? ISSUE : IDLE;
                    w_load      = w_grant_valid;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!w_active) begin
            w_state_nxt = IDLE;
            w_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_q  <= 1'b0;
            r_state     <= IDLE;
            r_pending   <= '0;
            r_last_hdr  <= '0;
            r_last_data <= '0;
            r_timer     <= '0;
            r_hold_cnt  <= '0;
            r_ptr       <= 2'd0;
            r_type      <= FC_P;
            r_hdr       <= '0;
            r_data      <= '0;
        end else begin
            r_active_q <= w_active;
            r_state    <= w_state_nxt;
            if (!w_active) begin
                r_pending   <= '0;
                r_timer     <= '0;
                r_last_hdr  <= '0;
                r_last_data <= '0;
            end else begin
                r_pending <= w_pend_nxt;
                r_timer   <= w_expire ? '0 : r_timer + TW'(1);
                if (w_issue) begin
                    r_last_hdr[r_type]  <= r_hdr;
                    r_last_data[r_type] <= r_data;
                    r_ptr               <= rr_next(r_type);
                end
            end
            if (w_load) begin
                r_hdr  <= w_hdr_in[w_grant_idx];
                r_data <= w_data_in[w_grant_idx];
                r_type <= fc_type_e'(w_grant_idx);
            end
            if (w_issue)
                r_hold_cnt <= HW'(HOLD_CYCLES - 1);
            else if ((r_state == HOLD) && (r_hold_cnt != '0))
                r_hold_cnt <= r_hold_cnt - HW'(1);
        end
    end

    assign hdr_credit_o  = r_hdr;
    assign data_credit_o = r_data;
    assign update_type_o = r_type;
    assign update_req_o  = w_issue && w_active;
endmodule

// File: tb/tb_dll_tx_fc_update_scheduler.sv
// Directed bench for the UpdateFC scheduler: a default-period instance for most
// scenarios and a 16-cycle-period instance for the refresh timer.
module tb_dll_tx_fc_update_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  dlc_state, d16_state;
    logic [7:0]  ph, nph, cplh;
    logic [11:0] pd, npd, cpld;
    logic [7:0]  hdr_m, hdr_t;
    logic [11:0] data_m, data_t;
    logic [1:0]  type_m, type_t;
    logic        req_m, req_t;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dll_tx_fc_update_scheduler u_dut (
        .clk(clk), .rst_n(rst_n), .dlc_state_i(dlc_state),
        .ph_alloc_i(ph), .pd_alloc_i(pd), .nph_alloc_i(nph), .npd_alloc_i(npd),
        .cplh_alloc_i(cplh), .cpld_alloc_i(cpld),
        .hdr_credit_o(hdr_m), .data_credit_o(data_m),
        .update_type_o(type_m), .update_req_o(req_m)
    );

    dll_tx_fc_update_scheduler #(.UPDATE_PERIOD(16), .HOLD_CYCLES(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .dlc_state_i(d16_state),
        .ph_alloc_i(ph), .pd_alloc_i(pd), .nph_alloc_i(nph), .npd_alloc_i(npd),
        .cplh_alloc_i(cplh), .cpld_alloc_i(cpld),
        .hdr_credit_o(hdr_t), .data_credit_o(data_t),
        .update_type_o(type_t), .update_req_o(req_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next strobe of the chosen instance, then checks
    // the gap in cycles and the fields presented with it.
    task automatic strobe(input string tag, input bit t16, input int exp_wait,
                          input logic [1:0] exp_type, input bit chk_val,
                          input logic [7:0] exp_hdr, input logic [11:0] exp_data);
        int  waited;
        logic seen;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            seen = t16 ? req_t : req_m;
        end
        chk({tag, "_wait"}, waited, exp_wait);
        chk({tag, "_type"}, t16 ? type_t : type_m, exp_type);
        if (chk_val) begin
            chk({tag, "_hdr"},  t16 ? hdr_t : hdr_m, exp_hdr);
            chk({tag, "_data"}, t16 ? data_t : data_m, exp_data);
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (req_m) cnt++;
        end
        chk(tag, cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0; dlc_state = 2'b00; d16_state = 2'b00;
        ph = 8'h00; nph = 8'h00; cplh = 8'h00;
        pd = 12'h000; npd = 12'h000; cpld = 12'h000;
        repeat (3) @(negedge clk);
        chk("rst_req", req_m, 0);
        chk("rst_hdr", hdr_m, 0);
        chk("rst_data", data_m, 0);
        chk("rst_type", type_m, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Link up: initial P, NP, Cpl updates
        dlc_state = 2'b11;
        strobe("t1_p",   0, 2, 2'b00, 1, 8'h00, 12'h000);
        strobe("t1_np",  0, 3, 2'b01, 1, 8'h00, 12'h000);
        strobe("t1_cpl", 0, 3, 2'b10, 1, 8'h00, 12'h000);
        quiet("t1_quiet", 8);

        ph = 8'h05; pd = 12'h123;
        strobe("t2_p5", 0, 2, 2'b00, 1, 8'h05, 12'h123);
        quiet("t2_quiet_a", 6);
        ph = 8'h07;
        strobe("t2_p7", 0, 2, 2'b00, 1, 8'h07, 12'h123);
        quiet("t2_quiet_b", 6);

        // Pointer now at NP: NP, Cpl, then P wraps last
        nph = 8'h11; cplh = 8'h22; ph = 8'h30;
        strobe("t3_np",  0, 2, 2'b01, 1, 8'h11, 12'h000);
        strobe("t3_cpl", 0, 3, 2'b10, 1, 8'h22, 12'h000);
        strobe("t3_p",   0, 3, 2'b00, 1, 8'h30, 12'h123);
        quiet("t3_quiet", 6);

        // Refresh timer on the 16-cycle instance
        d16_state = 2'b11;
        strobe("t4_p0",   1, 2,  2'b00, 1, 8'h30, 12'h123);
        strobe("t4_np0",  1, 3,  2'b01, 1, 8'h11, 12'h000);
        strobe("t4_cpl0", 1, 3,  2'b10, 1, 8'h22, 12'h000);
        strobe("t4_p1",   1, 9,  2'b00, 0, 8'h00, 12'h000);
        strobe("t4_np1",  1, 3,  2'b01, 0, 8'h00, 12'h000);
        strobe("t4_cpl1", 1, 3,  2'b10, 0, 8'h00, 12'h000);
        // P issue lands on the next expiry edge; P must be re-sent after Cpl
        repeat (6) @(negedge clk);
        ph = 8'h40;
        strobe("t4_p2",   1, 2, 2'b00, 1, 8'h40, 12'h123);
        strobe("t4_np2",  1, 3, 2'b01, 0, 8'h00, 12'h000);
        strobe("t4_cpl2", 1, 3, 2'b10, 0, 8'h00, 12'h000);
        strobe("t4_p3",   1, 3, 2'b00, 1, 8'h40, 12'h123);
        d16_state = 2'b00;
        quiet("t4_quiet", 6);

        pd = 12'hFFF;
        strobe("t5_pfff", 0, 2, 2'b00, 1, 8'h40, 12'hFFF);
        quiet("t5_quiet_a", 4);
        pd = 12'h000;
        strobe("t5_p000", 0, 2, 2'b00, 1, 8'h40, 12'h000);
        quiet("t5_quiet_b", 4);
        cpld = 12'h055;
        strobe("t5_cpl_a", 0, 2, 2'b10, 1, 8'h22, 12'h055);
        cpld = 12'h066;
        strobe("t5_cpl_b", 0, 3, 2'b10, 1, 8'h22, 12'h066);
        quiet("t5_quiet_c", 6);

        // Drop Active in the middle of an ISSUE
        nph = 8'h12;
        strobe("t6_np", 0, 2, 2'b01, 1, 8'h12, 12'h000);
        dlc_state = 2'b01;
        #1;
        chk("t6_drop_req", req_m, 0);
        ph = 8'h50;
        quiet("t6_inactive", 10);
        dlc_state = 2'b11;
        strobe("t6_p",   0, 2, 2'b00, 1, 8'h50, 12'h000);
        strobe("t6_np2", 0, 3, 2'b01, 1, 8'h12, 12'h000);
        strobe("t6_cpl", 0, 3, 2'b10, 1, 8'h22, 12'h066);
        quiet("t6_quiet", 6);

        // Asynchronous reset during an ISSUE
        ph = 8'h60;
        strobe("t7_p", 0, 2, 2'b00, 1, 8'h60, 12'h000);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_req", req_m, 0);
        chk("t7_rst_hdr", hdr_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
